// File: rtl/noc_inject_arbiter_pkg.sv
// Shared configuration for the NoC injection arbiter.
// Holds the per-instance NoC parameter sets (V, B, Fw selected by NOC_ID),
// the arbiter FSM state type and the pointer/credit width helpers.
package noc_inject_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } inj_arb_state_t;

  // Number of virtual channels for a NoC instance.
  function automatic int noc_conf_v(input int noc_id);
    case (noc_id)
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Downstream buffer depth (credits) per VC.
  function automatic int noc_conf_b(input int noc_id);
    case (noc_id)
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Flit width.
  function automatic int noc_conf_fw(input int noc_id);
    case (noc_id)
      1:       return 64;
      default: return 32;
    endcase
  endfunction

  // INJ_PTRw: width of the round-robin pointer / requester index.
  function automatic int inj_ptrw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // INJ_CRDw: width of a credit counter able to hold 0..B.
  function automatic int inj_crdw(input int b);
    return $clog2(b + 1);
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Injection-side bus between the local flit sources and the arbiter.
//   req_valid/req_flit/req_head/req_tail/req_vc : per-requester flit offer
//   req_ready                                   : per-requester accept
//   flit_out/flit_out_wr/flit_out_vc            : endpoint flit channel
//   credit_in                                   : per-VC credit return
//   credit_err                                  : sticky credit overflow
// Modports: master = sources/endpoint side, slave = arbiter.
interface noc_inject_arbiter_if
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int V    = noc_conf_v(0),
  parameter int Fw   = noc_conf_fw(0)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*Fw-1:0] req_flit;
  logic [NREQ-1:0]    req_head;
  logic [NREQ-1:0]    req_tail;
  logic [NREQ*V-1:0]  req_vc;
  logic [NREQ-1:0]    req_ready;
  logic [Fw-1:0]      flit_out;
  logic               flit_out_wr;
  logic [V-1:0]       flit_out_vc;
  logic [V-1:0]       credit_in;
  logic               credit_err;

  modport master (
    output req_valid, req_flit, req_head, req_tail, req_vc, credit_in,
    input  req_ready, flit_out, flit_out_wr, flit_out_vc, credit_err
  );

  modport slave (
    input  req_valid, req_flit, req_head, req_tail, req_vc, credit_in,
    output req_ready, flit_out, flit_out_wr, flit_out_vc, credit_err
  );
endinterface

// File: rtl/noc_inject_arbiter_credit.sv
// inj_credit_counter: credit counter for one downstream VC.
// Resets to B, decrements on a flit accepted on the VC, increments on a
// credit return. A return while already at B holds the count and raises a
// sticky err until reset.
//   clk, reset (sync, active-low), dec, inc -> cnt, err
module inj_credit_counter #(
  parameter int B = 4,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         err
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= W'(B);
      err <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt == W'(B)) err <= 1'b1;
          else              cnt <= cnt + 1'b1;
        end
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: packet-granular round-robin arbiter sharing one NoC
// endpoint injection port among NREQ flit sources, with per-VC credit
// tracking and a grant locked from head to tail flit.
//   clk, reset (sync, active-low)
//   bus     : noc_inject_arbiter_if.slave (requests, endpoint flit channel,
//             credit return, credit_err)
//   pkt_cnt : NREQ x 16-bit tail-flit counts, only when INJ_ARB_PKT_CNT_EN
//             is defined
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NOC_ID = 0,
  parameter int NREQ   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  noc_inject_arbiter_if.slave   bus
`ifdef INJ_ARB_PKT_CNT_EN
  ,
  output logic [NREQ*16-1:0]    pkt_cnt
`endif
);
  localparam int V        = noc_conf_v(NOC_ID);
  localparam int B        = noc_conf_b(NOC_ID);
  localparam int Fw       = noc_conf_fw(NOC_ID);
  localparam int INJ_PTRw = inj_ptrw(NREQ);
  localparam int INJ_CRDw = inj_crdw(B);

  inj_arb_state_t      state;
  logic [INJ_PTRw-1:0] ptr;
  logic [INJ_PTRw-1:0] owner;
  logic [V-1:0]        cur_vc;

  logic [INJ_PTRw-1:0] grant;
  logic [INJ_PTRw-1:0] cand;
  logic                found;
  logic [NREQ-1:0]     ready;
  logic [V-1:0]        acc_vc;
  logic                accept;

  logic [V-1:0]        crd_avail;
  logic [V-1:0]        crd_dec;
  logic [V-1:0]        crd_err;
  logic [INJ_CRDw-1:0] crd_cnt [V];

  function automatic logic [INJ_PTRw-1:0] ptr_next(input logic [INJ_PTRw-1:0] p);
    return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

  for (genvar v = 0; v < V; v++) begin : g_crd
    inj_credit_counter #(.B(B), .W(INJ_CRDw)) u_crd (
      .clk   (clk),
      .reset (reset),
      .dec   (crd_dec[v]),
      .inc   (bus.credit_in[v]),
      .cnt   (crd_cnt[v]),
      .err   (crd_err[v])
    );
    assign crd_avail[v] = (crd_cnt[v] != '0);
  end

  // Grant is a function of registered state only; credit_in reaches it
  // through the counters, one cycle later.
  always_comb begin
    ready  = '0;
    grant  = '0;
    cand   = '0;
    found  = 1'b0;
    acc_vc = cur_vc;
    if (reset) begin
      if (state == IDLE) begin
        for (int k = 0; k < NREQ; k++) begin
          cand = INJ_PTRw'((int'(ptr) + k) % NREQ);
          if (!found && bus.req_valid[cand] && bus.req_head[cand] &&
              |(bus.req_vc[cand*V +: V] & crd_avail)) begin
            found = 1'b1;
            grant = cand;
          end
        end
        ready[grant] = found;
        acc_vc       = bus.req_vc[grant*V +: V];
      end else begin
        grant        = owner;
        ready[owner] = |(cur_vc & crd_avail);
      end
    end
  end

  assign accept         = |(bus.req_valid & ready);
  assign crd_dec        = accept ? acc_vc : '0;
  assign bus.req_ready  = ready;
  assign bus.credit_err = |crd_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      ptr             <= '0;
      owner           <= '0;
      cur_vc          <= '0;
      bus.flit_out    <= '0;
      bus.flit_out_wr <= 1'b0;
      bus.flit_out_vc <= '0;
    end else begin
      bus.flit_out_wr <= accept;
      if (accept) begin
        bus.flit_out    <= bus.req_flit[grant*Fw +: Fw];
        bus.flit_out_vc <= acc_vc;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.req_tail[grant]) begin
              ptr <= ptr_next(grant);
            end else begin
              state  <= LOCKED;
              owner  <= grant;
              cur_vc <= acc_vc;
            end
          end
        end
        LOCKED: begin
          if (accept && bus.req_tail[owner]) begin
            state <= IDLE;
            ptr   <= ptr_next(owner);
          end
        end
      endcase
    end
  end

`ifdef INJ_ARB_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_cnt <= '0;
    end else if (accept && bus.req_tail[grant]) begin
      pkt_cnt[grant*16 +: 16] <= pkt_cnt[grant*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Packet-granular round-robin arbiter that shares one NoC endpoint injection port among NREQ local flit sources (DMA, traffic generator, NI request/response queues) in front of `noc_top`. Tracks per-VC downstream credits, locks the grant from head to tail flit, and drives one endpoint flit channel with registered outputs.

## Interface
- `NOC_ID`, 0: NoC instance; selects the `NOC_CONF` parameter set (supplies `V`, `B`, `Fw`).
- `NREQ`, 4: number of requesters; 2..16.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low reset: sampled on the rising edge of `clk`, asserted when 0.
- `req_valid`  in  NREQ  flit valid per requester.
- `req_flit`  in  NREQ*Fw  flit data per requester.
- `req_head`  in  NREQ  flit is a head flit.
- `req_tail`  in  NREQ  flit is a tail flit; head and tail together mark a single-flit packet.
- `req_vc`  in  NREQ*V  one-hot target VC per requester; sampled on head only.
- `req_ready`  out  NREQ  flit accepted this cycle when `req_valid & req_ready`.
- `flit_out`  out  Fw  flit to endpoint `chan_in_all[i].flit_chanel.flit`.
- `flit_out_wr`  out  1  flit write strobe.
- `flit_out_vc`  out  V  one-hot VC of `flit_out`.
- `credit_in`  in  V  per-VC credit return from endpoint `chan_out_all[i].flit_chanel.credit`.
- `credit_err`  out  1  sticky: credit returned on a VC already holding B credits.

## Operation
- States: IDLE, LOCKED.
- IDLE: eligible requester = `req_valid & req_head` and credit count of its `req_vc` > 0. Winner = first eligible at or after priority pointer `ptr`, wrapping mod NREQ. Only winner sees `req_ready=1`. Non-head flits in IDLE are never accepted.
- Head accepted without tail -> LOCKED; latch `owner` and `cur_vc`. Head+tail accepted -> stay IDLE; `ptr <= owner+1` (mod NREQ).
- LOCKED: `req_ready[owner] = credit[cur_vc] > 0`; all other requesters 0. `req_vc` ignored. Tail accepted -> IDLE, `ptr <= owner+1` (mod NREQ).
- Credits: V counters, width clog2(B+1), reset to B. Decrement on acceptance of a flit on that VC; increment on `credit_in[v]`. Simultaneous decrement and increment on the same VC -> unchanged. Increment at B -> counter held at B, `credit_err` set until reset.
- Counter 0 with a pending flit -> stall. Grant held, no timeout; the arbiter does not re-arbitrate mid-packet.
- Reset mid-packet: state IDLE, `ptr`=0, credits B, packet truncated. Requesters flush their own state on the same reset.

## Timing
- Reset values: `req_ready`=0, `flit_out`=0, `flit_out_wr`=0, `flit_out_vc`=0, `credit_err`=0, `pkt_cnt`=0.
- `req_ready` is combinational from state, `ptr`, credit registers and `req_valid/req_head/req_vc`. No combinational path from `credit_in`.
- Accepted flit appears on `flit_out`/`flit_out_wr`/`flit_out_vc` exactly 1 cycle later. `flit_out` holds its value when `flit_out_wr`=0.
- `credit_in` at cycle t is usable for acceptance at t+1.
- Back-to-back flits at 1 per cycle while credit > 0. A new head can be granted in the cycle after a tail.

## Configuration
- `INJ_ARB_PKT_CNT_EN` defined: adds output `pkt_cnt` (NREQ*16), a per-requester count of tail flits accepted. Each count wraps at 2^16 and resets to 0.
- Not defined: no `pkt_cnt` port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `pronoc_pkg` (via `NOC_CONF`) holds `V`, `B`, `Fw`. Add typedef `inj_arb_state_t` {IDLE, LOCKED}, plus constants `INJ_PTRw = clog2(NREQ)` and `INJ_CRDw = clog2(B+1)`.
- One sub-module: `inj_credit_counter` (single-VC up/down counter with saturation and error flag), instantiated V times.
- Round-robin select stays inline.

## Test plan
- Reset: reset=0 for 2 cycles with all `req_valid`=1 -> all outputs 0. After release, all credits = B (B=4).
- Fairness: all 4 requesters send continuous 2-flit packets on VC0, with credit returned each cycle. Grant order is 0,1,2,3,0, with no foreign flit between a head and its tail.
- Credit stall: B=4, 6-flit packet, `credit_in`=0 -> 4 flits on `flit_out`, then `req_ready`=0. One `credit_in[0]` pulse -> exactly one more flit, 2 cycles after the pulse.
- VC independence: VC0 credits 0, requester 1 head on VC1 -> requester 1 granted while requester 0 on VC0 is skipped.
- Simultaneous events: accept a VC2 flit and `credit_in[2]` in the same cycle -> VC2 count unchanged. `credit_in[2]` with count 4 -> `credit_err`=1 and count stays 4.
- Single-flit and reset: head+tail from requester 3 -> FSM stays IDLE and `ptr`=0. Reset asserted mid-packet in LOCKED -> IDLE; the next head from any requester is accepted.
